blink_monitor: RTL and testbench
================================

# blink_monitor

Receive-side counterpart of the board's LED blinker. It watches an asynchronous square-wave input (a blink/heartbeat line), measures the interval between consecutive edges in CLOCK_50 cycles and checks each interval against the expected half-period. It reports lock, stuck-line and edge-count status for on-board self-test and heartbeat supervision.

## Interface
Parameters:
- HALF_PERIOD, 50_000_000: expected cycles between consecutive edges.
- TOL, 500_000: allowed absolute deviation from HALF_PERIOD, in cycles.
- TIMEOUT, 100_000_000: cycles without an edge before the stuck flag is raised.
- LOCK_COUNT, 4: consecutive in-tolerance intervals required for lock.
- CNT_W, 27: counter/period width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  reset, synchronous, active-high; clock CLOCK_50.
- blink_in  in  1  asynchronous monitored line.
- period  out  CNT_W  last measured edge-to-edge interval, in cycles.
- period_valid  out  1  one-cycle pulse when period updates.
- edge_count  out  16  detected edges, saturating at 0xFFFF.
- locked  out  1  LOCK_COUNT consecutive intervals within tolerance.
- stuck  out  1  no edge for TIMEOUT cycles.

## Operation
- blink_in passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. edge = s2 XOR s3; both polarities count.
- All synchronizer flops reset to 0. If blink_in is high at reset release, the resulting edge is treated as the first edge (IDLE to MEASURE, no period produced).
- Interval counter cnt:
  - On an edge cycle: interval = cnt + 1, then cnt <= 0.
  - Otherwise cnt increments in MEASURE and LOCKED.
  - If edges are detected at cycles t0 and t1, the interval is t1 - t0.
- In-tolerance test: |interval - HALF_PERIOD| <= TOL, computed at CNT_W+1 bits signed. No wrap is possible because cnt never exceeds TIMEOUT.
- good_cnt counts consecutive in-tolerance intervals and saturates at LOCK_COUNT.
- edge_count increments on every detected edge, including the first and the one that leaves STUCK. It saturates and never wraps.
- States:
  - IDLE: reset state; cnt held at 0. Edge: go to MEASURE, cnt <= 0, no period_valid.
  - MEASURE: on edge, load period and pulse period_valid. In tolerance: good_cnt++; reaching LOCK_COUNT moves to LOCKED. Out of tolerance: good_cnt <= 0.
  - LOCKED: locked = 1. Edges update period as in MEASURE. An out-of-tolerance interval moves to MEASURE with good_cnt <= 0.
  - STUCK: entered from MEASURE or LOCKED when cnt reaches TIMEOUT-1 with no edge that cycle. Sets stuck = 1, good_cnt <= 0, cnt frozen. Next edge: go to MEASURE, cnt <= 0, stuck cleared, no period_valid (the interval is invalid).
- Simultaneous edge and timeout in the same cycle: the edge wins; the interval equals TIMEOUT and is judged normally.
- Reset asserted at any time, including mid-interval: every flop returns to its reset value at the next clock edge and the state returns to IDLE.

## Timing
- All outputs are registered. Reset values: period = 0, period_valid = 0, edge_count = 0, locked = 0, stuck = 0.
- Latency from a blink_in transition to the edge cycle: 2–3 cycles (synchronizer uncertainty).
- Edge cycle to update of period, period_valid, edge_count and state: 1 clock.
- locked rises in the same cycle as the period_valid pulse of the LOCK_COUNT-th good interval. It falls in the same cycle as the period_valid pulse of the first bad interval.
- stuck rises on the clock edge after cnt reaches TIMEOUT-1. It falls one clock after the next detected edge.
- period holds its value between updates, including through STUCK.

## Structure
- Package blink_pkg contains:
  - the state enum (IDLE, MEASURE, LOCKED, STUCK);
  - default constants HALF_PERIOD_50M = 50_000_000, TOL_DEF, TIMEOUT_DEF, LOCK_COUNT_DEF.
- Sub-module sync_edge_detect holds the 2-flop synchronizer and history flop, with outputs level and edge. It is reusable for pushbutton inputs.
- Top level holds the interval counter, tolerance comparator, state machine and output registers.

## Test plan
Bench parameters for all scenarios: HALF_PERIOD = 100, TOL = 2, TIMEOUT = 300, LOCK_COUNT = 4.
- Reset, then toggle blink_in every 100 cycles for 6 edges -> period = 100 with period_valid at edges 2–6; locked = 1 at the 5th edge; edge_count = 6.
- While locked, one interval of 110 -> period = 110, locked = 0 in the same cycle; then 4 intervals of 100 -> locked = 1 again.
- Intervals 102, 98, 102, 98 -> locked = 1. A following interval of 103 -> locked = 0.
- Stop toggling -> stuck = 1 exactly 300 cycles after the last edge, period unchanged. The next edge gives stuck = 0 with no period_valid; the edge after it at +100 gives period = 100.
- Assert reset for one cycle 50 cycles into a locked interval -> all outputs 0 at the next clock and state IDLE. The first edge after reset produces no period_valid.
- Toggle blink_in every 4 cycles for 70000 edges -> locked stays 0, period = 4, edge_count stops at 0xFFFF without wrapping.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and default constants for the heartbeat/blink monitor.
package blink_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STUCK} state_t;

  localparam int HALF_PERIOD_50M = 50_000_000;
  localparam int TOL_DEF         = 500_000;
  localparam int TIMEOUT_DEF     = 100_000_000;
  localparam int LOCK_COUNT_DEF  = 4;
endpackage

// File: rtl/blink_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus history flop; flags either polarity of transition.
// Suitable for any slow asynchronous input such as a pushbutton.
module sync_edge_detect (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic edge_det
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level    = s2_q;
  assign edge_det = s2_q ^ s3_q;
endmodule

// File: rtl/blink_monitor.sv
// Measures edge-to-edge intervals of an async square wave and reports
// lock, stuck-line and edge-count status.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_50M,
  parameter int TOL         = TOL_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int CNT_W       = 27
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             blink_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [15:0]      edge_count,
  output logic             locked,
  output logic             stuck
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]           LC_G    = GW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]        TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [CNT_W:0]   HP_S    = (CNT_W+1)'(HALF_PERIOD);
  localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W+1)'(TOL);

  logic level_unused, edge_det;

  sync_edge_detect u_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (blink_in),
    .level    (level_unused),
    .edge_det (edge_det)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic [15:0]      edge_count_q, edge_count_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;

  logic [CNT_W-1:0]   interval;
  logic signed [CNT_W:0] diff;
  logic               in_tol;

  // cnt never exceeds TIMEOUT-1, so one extra sign bit cannot overflow
  assign interval = cnt_q + 1'b1;
  assign diff     = $signed({1'b0, interval}) - HP_S;
  assign in_tol   = (diff <= TOL_S) && (diff >= -TOL_S);
  assign good_inc = (good_q == LC_G) ? good_q : good_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_d         = good_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    edge_count_d   = edge_count_q;
    if (edge_det && edge_count_q != 16'hFFFF) edge_count_d = edge_count_q + 16'd1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_det) state_d = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (edge_det) begin
          cnt_d          = '0;
          period_d       = interval;
          period_valid_d = 1'b1;
          if (in_tol) begin
            good_d = good_inc;
            if (good_inc == LC_G) state_d = LOCKED;
          end else begin
            good_d  = '0;
            state_d = MEASURE;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = STUCK;
          good_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STUCK: begin
        // first edge after a stall only restarts timing; its interval is meaningless
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d = (state_d == LOCKED);
    stuck_d  = (state_d == STUCK);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      good_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      edge_count_q   <= '0;
      locked_q       <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      edge_count_q   <= edge_count_d;
      locked_q       <= locked_d;
      stuck_q        <= stuck_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign edge_count   = edge_count_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;
endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor with a 100-cycle half period.
module tb_blink_monitor;
  import blink_pkg::*;

  localparam int CNT_W = 12;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic             blink_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [15:0]      edge_count;
  logic             locked;
  logic             stuck;

  blink_monitor #(
    .HALF_PERIOD (100),
    .TOL         (2),
    .TIMEOUT     (300),
    .LOCK_COUNT  (4),
    .CNT_W       (CNT_W)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .blink_in     (blink_in),
    .period       (period),
    .period_valid (period_valid),
    .edge_count   (edge_count),
    .locked       (locked),
    .stuck        (stuck)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int   checks = 0;
  int   errors = 0;
  int   pv_cnt;
  int   pv_per;
  logic pv_lock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // one clock; sample 1 time unit after the edge and log any period pulse
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    if (period_valid) begin
      pv_cnt++;
      pv_per  = period;
      pv_lock = locked;
    end
  endtask

  // toggle blink_in gap cycles after the previous toggle; the pulse lands in the last 4 steps
  task automatic edge_at(input int gap);
    pv_cnt = 0;
    repeat (gap - 4) step();
    blink_in = ~blink_in;
    repeat (4) step();
  endtask

  task automatic fast_toggle(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
      blink_in = ~blink_in;
    end
    repeat (5) step();
  endtask

  initial begin
    int iv2 [4];
    iv2 = '{102, 98, 102, 98};
    reset    = 1'b1;
    blink_in = 1'b0;
    pv_cnt   = 0;
    pv_per   = 0;
    pv_lock  = 1'b0;
    repeat (3) step();
    chk("rst_period", 32'(period), 0);
    chk("rst_pv", 32'(period_valid), 0);
    chk("rst_ec", 32'(edge_count), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_stuck", 32'(stuck), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    repeat (10) step();

    // steady 100-cycle toggling
    edge_at(100);
    chk("first_pv", pv_cnt, 0);
    chk("first_state", 32'(dut.state_q), 32'(MEASURE));
    for (int i = 2; i <= 6; i++) begin
      edge_at(100);
      chk("s1_pv", pv_cnt, 1);
      chk("s1_period", pv_per, 100);
      chk("s1_lock", 32'(pv_lock), (i >= 5) ? 32'd1 : 32'd0);
    end
    chk("s1_ec", 32'(edge_count), 6);

    // one long interval breaks lock, four good ones restore it
    edge_at(110);
    chk("s2_pv", pv_cnt, 1);
    chk("s2_period", pv_per, 110);
    chk("s2_unlock", 32'(pv_lock), 0);
    for (int i = 0; i < 4; i++) begin
      edge_at(100);
      chk("s2_relock", 32'(pv_lock), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("s2_ec", 32'(edge_count), 11);

    // tolerance boundaries
    edge_at(110);
    chk("s3_unlock", 32'(pv_lock), 0);
    for (int i = 0; i < 4; i++) begin
      edge_at(iv2[i]);
      chk("s3_period", pv_per, iv2[i]);
      chk("s3_lock", 32'(pv_lock), (i == 3) ? 32'd1 : 32'd0);
    end
    edge_at(103);
    chk("s3_period103", pv_per, 103);
    chk("s3_lock103", 32'(pv_lock), 0);
    chk("s3_ec", 32'(edge_count), 17);

    // stall: stuck exactly 300 cycles after the last period pulse
    pv_cnt = 0;
    repeat (298) step();
    chk("s4_stuck_early", 32'(stuck), 0);
    step();
    chk("s4_stuck", 32'(stuck), 1);
    chk("s4_period_hold", 32'(period), 103);
    chk("s4_no_pv", pv_cnt, 0);
    repeat (20) step();
    chk("s4_stuck_hold", 32'(stuck), 1);
    edge_at(4);
    chk("s4_exit_pv", pv_cnt, 0);
    chk("s4_exit_stuck", 32'(stuck), 0);
    chk("s4_exit_ec", 32'(edge_count), 18);
    chk("s4_exit_period", 32'(period), 103);
    edge_at(100);
    chk("s4_next_pv", pv_cnt, 1);
    chk("s4_next_period", pv_per, 100);

    // reset in the middle of a locked interval
    repeat (3) edge_at(100);
    chk("s5_locked", 32'(locked), 1);
    repeat (46) step();
    reset    = 1'b1;
    blink_in = 1'b0;
    step();
    chk("s5_period", 32'(period), 0);
    chk("s5_pv", 32'(period_valid), 0);
    chk("s5_ec", 32'(edge_count), 0);
    chk("s5_locked0", 32'(locked), 0);
    chk("s5_stuck", 32'(stuck), 0);
    chk("s5_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    repeat (10) step();
    chk("s5_ec_idle", 32'(edge_count), 0);
    edge_at(20);
    chk("s5_first_pv", pv_cnt, 0);
    chk("s5_first_ec", 32'(edge_count), 1);
    chk("s5_first_state", 32'(dut.state_q), 32'(MEASURE));

    // fast toggling: never locks, edge counter saturates
    for (int i = 0; i < 20; i++) edge_at(4);
    chk("s6_period4", pv_per, 4);
    chk("s6_lock_pv", 32'(pv_lock), 0);
    chk("s6_locked", 32'(locked), 0);
    chk("s6_ec21", 32'(edge_count), 21);
    fast_toggle(1000);
    chk("s6_ec1021", 32'(edge_count), 1021);
    chk("s6_period1", 32'(period), 1);
    fast_toggle(64600);
    chk("s6_ec_sat", 32'(edge_count), 32'hFFFF);
    fast_toggle(200);
    chk("s6_ec_nowrap", 32'(edge_count), 32'hFFFF);
    chk("s6_locked_end", 32'(locked), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
